// File: rtl/io_agent_pkg.sv
// Shared types and constants for the CPU I/O port agent.
package io_agent_pkg;

    localparam int BYTE_W = 8;

    // err_flags layout: {tx_overflow, rx_underflow}
    localparam int ERR_RX_UNDERFLOW = 0;
    localparam int ERR_TX_OVERFLOW  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } int_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head byte, occupancy count and full/empty flags.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_rd_next;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_head;

    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            // Head is precomputed so the consumer sees it straight from a flop.
            if (w_pop) begin
                if (r_count == CW'(1)) begin
                    r_head <= i_data;
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end else if (o_empty && w_push) begin
                r_head <= i_data;
            end
        end
    end

endmodule

// File: rtl/io_port_agent.sv
// Peripheral partner of the CPU I/O ports: RX FIFO toward I_Port, TX FIFO from O_Port,
// and a one-shot interrupt raised when input arrives in an empty RX queue.
module io_port_agent
    import io_agent_pkg::*;
#(
    parameter int                DEPTH     = 8,
    parameter logic [BYTE_W-1:0] EMPTY_VAL = 8'h00,
    parameter int                INT_PULSE = 2,
    parameter bit                INT_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [BYTE_W-1:0]      host_in_data,
    input  logic                   host_in_valid,
    output logic                   host_in_ready,
    output logic [BYTE_W-1:0]      cpu_in_port,
    input  logic                   cpu_in_rd,
    input  logic [BYTE_W-1:0]      cpu_out_port,
    input  logic                   cpu_out_wr,
    output logic [BYTE_W-1:0]      host_out_data,
    output logic                   host_out_valid,
    input  logic                   host_out_ready,
    output logic                   int_sig,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [1:0]             err_flags
);

    localparam int PW = $clog2(INT_PULSE + 1);

    logic [BYTE_W-1:0] w_rx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_tx_push;
    logic              w_tx_pop;

    int_state_t        r_state;
    logic [PW-1:0]     r_int_cnt;
    logic              r_int;
    logic [1:0]        r_err;

    assign w_rx_push = host_in_valid && !w_rx_full;
    assign w_rx_pop  = cpu_in_rd && !w_rx_empty;
    assign w_tx_push = cpu_out_wr && !w_tx_full;
    assign w_tx_pop  = host_out_ready && !w_tx_empty;

    sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_rx_push),
        .i_data  (host_in_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_count (rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_tx_push),
        .i_data  (cpu_out_port),
        .i_pop   (w_tx_pop),
        .o_head  (host_out_data),
        .o_count (tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign host_in_ready  = !w_rx_full;
    assign host_out_valid = !w_tx_empty;
    assign cpu_in_port    = w_rx_empty ? EMPTY_VAL : w_rx_head;
    assign int_sig        = r_int;
    assign err_flags      = r_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            if (cpu_in_rd && w_rx_empty) begin
                r_err[ERR_RX_UNDERFLOW] <= 1'b1;
            end
            // Full is taken from the registered count, so a same-cycle host pop cannot save the byte.
            if (cpu_out_wr && w_tx_full) begin
                r_err[ERR_TX_OVERFLOW] <= 1'b1;
            end
        end
    end

    // One interrupt per batch of input: after the pulse, stay quiet until RX has drained.
    always_ff @(posedge clk) begin
        if (!rstn || !INT_EN) begin
            r_state   <= ST_IDLE;
            r_int_cnt <= '0;
            r_int     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_push && w_rx_empty) begin
                        r_state   <= ST_PULSE;
                        r_int_cnt <= PW'(INT_PULSE);
                        r_int     <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_int_cnt <= PW'(1)) begin
                        r_state <= ST_WAIT;
                        r_int   <= 1'b0;
                    end else begin
                        r_int_cnt <= r_int_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_rx_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_agent.sv
// Scoreboard bench for io_port_agent: the driver advances a queue-based reference model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_io_port_agent;
    import io_agent_pkg::*;

    localparam int DEPTH     = 8;
    localparam int INT_PULSE = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic [7:0]    host_in_data;
    logic          host_in_valid;
    logic          host_in_ready;
    logic [7:0]    cpu_in_port;
    logic          cpu_in_rd;
    logic [7:0]    cpu_out_port;
    logic          cpu_out_wr;
    logic [7:0]    host_out_data;
    logic          host_out_valid;
    logic          host_out_ready;
    logic          int_sig;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic [1:0]    err_flags;

    io_port_agent #(
        .DEPTH     (DEPTH),
        .EMPTY_VAL (8'h00),
        .INT_PULSE (INT_PULSE),
        .INT_EN    (1'b1)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_in_port    (cpu_in_port),
        .cpu_in_rd      (cpu_in_rd),
        .cpu_out_port   (cpu_out_port),
        .cpu_out_wr     (cpu_out_wr),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .int_sig        (int_sig),
        .rx_count       (rx_count),
        .tx_count       (tx_count),
        .err_flags      (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            chk;
        logic [7:0]    cpu_in;
        logic          in_rdy;
        logic          out_vld;
        logic [7:0]    out_data;
        logic [CW-1:0] rxc;
        logic [CW-1:0] txc;
        logic [1:0]    err;
        logic          intr;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       exp_q[$];
    logic [7:0] tx_sb_q[$];

    // Reference model: byte queues plus interrupt bookkeeping.
    logic [7:0] rx_m[$];
    logic [7:0] tx_m[$];
    logic [1:0] m_err     = 2'b00;
    int         m_int_rem = 0;
    bit         m_armed   = 1'b1;
    bit         m_valid   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.chk      = m_valid;
        e.cpu_in   = (rx_m.size() != 0) ? rx_m[0] : 8'h00;
        e.in_rdy   = (rx_m.size() != DEPTH);
        e.out_vld  = (tx_m.size() != 0);
        e.out_data = (tx_m.size() != 0) ? tx_m[0] : 8'h00;
        e.rxc      = CW'(rx_m.size());
        e.txc      = CW'(tx_m.size());
        e.err      = m_err;
        e.intr     = (m_int_rem > 0);
        return e;
    endfunction

    // One clock of stimulus: queue the expectation for the state now visible, then drive the
    // inputs for the next edge and advance the model through that edge.
    task automatic step(input bit r, input bit iv, input logic [7:0] id, input bit rd,
                        input bit wr, input logic [7:0] wd, input bit ordy);
        bit rxe, rxf, txe, txf, rxpush, rxpop, txpush, txpop;
        @(posedge clk);
        #2;
        exp_q.push_back(model_view());
        if (!r) begin
            rstn           = 1'b0;
            host_in_valid  = 1'b0;
            host_in_data   = 8'h00;
            cpu_in_rd      = 1'b0;
            cpu_out_wr     = 1'b0;
            cpu_out_port   = 8'h00;
            host_out_ready = 1'b0;
            rx_m.delete();
            tx_m.delete();
            tx_sb_q.delete();
            m_err     = 2'b00;
            m_int_rem = 0;
            m_armed   = 1'b1;
            m_valid   = 1'b1;
            return;
        end
        rstn           = 1'b1;
        host_in_valid  = iv;
        host_in_data   = id;
        cpu_in_rd      = rd;
        cpu_out_wr     = wr;
        cpu_out_port   = wd;
        host_out_ready = ordy;

        rxe    = (rx_m.size() == 0);
        rxf    = (rx_m.size() == DEPTH);
        txe    = (tx_m.size() == 0);
        txf    = (tx_m.size() == DEPTH);
        rxpush = iv && !rxf;
        rxpop  = rd && !rxe;
        txpush = wr && !txf;
        txpop  = ordy && !txe;

        if (rd && rxe) m_err[0] = 1'b1;
        if (wr && txf) m_err[1] = 1'b1;

        if (m_armed) begin
            if (rxpush && rxe) begin
                m_armed   = 1'b0;
                m_int_rem = INT_PULSE;
            end
        end else if (m_int_rem > 0) begin
            m_int_rem--;
        end else if (rxe) begin
            m_armed = 1'b1;
        end

        if (rxpop) void'(rx_m.pop_front());
        if (rxpush) rx_m.push_back(id);
        if (txpop) void'(tx_m.pop_front());
        if (txpush) begin
            tx_m.push_back(wd);
            tx_sb_q.push_back(wd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        step(1, 1, b, 0, 0, 8'h00, 0);
    endtask

    task automatic cpu_rd();
        step(1, 0, 8'h00, 1, 0, 8'h00, 0);
    endtask

    task automatic cpu_wr(input logic [7:0] b);
        step(1, 0, 8'h00, 0, 1, b, 0);
    endtask

    task automatic host_pop();
        step(1, 0, 8'h00, 0, 0, 8'h00, 1);
    endtask

    // Monitor: compares the queued expectation each cycle and scores every TX handshake.
    exp_t       mon_e;
    logic [7:0] mon_b;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
                check("cpu_in_port",    32'(cpu_in_port),    32'(mon_e.cpu_in));
                check("host_in_ready",  32'(host_in_ready),  32'(mon_e.in_rdy));
                check("host_out_valid", 32'(host_out_valid), 32'(mon_e.out_vld));
                if (mon_e.out_vld)
                    check("host_out_data", 32'(host_out_data), 32'(mon_e.out_data));
                check("rx_count",       32'(rx_count),       32'(mon_e.rxc));
                check("tx_count",       32'(tx_count),       32'(mon_e.txc));
                check("err_flags",      32'(err_flags),      32'(mon_e.err));
                check("int_sig",        32'(int_sig),        32'(mon_e.intr));
            end
        end
        if (rstn === 1'b1 && host_out_valid === 1'b1 && host_out_ready === 1'b1) begin
            if (tx_sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_handshake @%0t: got byte %0h, expected no pending byte", $time, host_out_data);
            end else begin
                mon_b = tx_sb_q.pop_front();
                check("tx_popped_byte", 32'(host_out_data), 32'(mon_b));
            end
        end
    end

    initial begin
        rstn           = 1'b0;
        host_in_valid  = 1'b0;
        host_in_data   = 8'h00;
        cpu_in_rd      = 1'b0;
        cpu_out_wr     = 1'b0;
        cpu_out_port   = 8'h00;
        host_out_ready = 1'b0;

        // Reset for two clocks.
        step(0, 0, 8'h00, 0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0);
        idle(2);

        // RX ordering and drain to EMPTY_VAL.
        push_rx(8'h05);
        push_rx(8'h03);
        push_rx(8'h09);
        idle(2);
        cpu_rd();
        idle(1);
        cpu_rd();
        cpu_rd();
        idle(2);

        // Interrupt: one pulse per batch, re-armed only after drain.
        push_rx(8'h11);
        idle(3);
        push_rx(8'h22);
        idle(3);
        cpu_rd();
        cpu_rd();
        idle(2);
        push_rx(8'h33);
        cpu_rd();
        idle(4);

        // TX ordering.
        cpu_wr(8'h08);
        cpu_wr(8'h05);
        idle(1);
        host_pop();
        host_pop();
        idle(2);

        // TX overflow, then RX underflow.
        for (int i = 0; i < DEPTH; i++) cpu_wr(8'($urandom_range(8'h9f)));
        cpu_wr(8'hAA);
        idle(1);
        for (int i = 0; i < DEPTH; i++) host_pop();
        idle(1);
        cpu_rd();
        idle(2);

        // RX full with simultaneous push+pop, then reset mid-burst.
        for (int i = 0; i < DEPTH; i++) push_rx(8'(8'h40 + i));
        step(1, 1, 8'h77, 1, 0, 8'h00, 0);
        step(1, 1, 8'h66, 1, 1, 8'h12, 0);
        push_rx(8'h55);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                step(0, 0, 8'h00, 0, 0, 8'h00, 0);
            end else begin
                step(1,
                     ($urandom_range(99) < 55),
                     8'($urandom),
                     ($urandom_range(99) < 40),
                     ($urandom_range(99) < 45),
                     8'($urandom),
                     ($urandom_range(99) < 40));
            end
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
